// File: rtl/i2c_apb_pkg.sv
// Shared types and constants for the I2C-to-APB master stage.
package i2c_apb_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    typedef struct packed {
        logic                  write;
        logic [I2C_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/apb_timeout_ctr.sv
// Saturating wait-state counter; expired flags the last permitted ACCESS cycle.
module apb_timeout_ctr #(
    parameter int LIMIT = 16,
    parameter int W     = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [W-1:0] MAX  = '1;
    localparam logic [W-1:0] LAST = (LIMIT == 0) ? '0 : W'(LIMIT - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && count != MAX) begin
            count <= count + W'(1);
        end
    end

    // LIMIT of zero disables the timeout entirely.
    assign expired = (LIMIT != 0) && (count == LAST);

endmodule

// File: rtl/i2c_apb_master.sv
// Runs one APB SETUP/ACCESS transfer per I2C request and returns rdata/err.
// Handshakes: a transfer moves on an edge where valid and ready are both 1;
// the sender holds valid and its payload stable until that edge.
module i2c_apb_master
    import i2c_apb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [I2C_ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_W-1:0]     paddr,
    output logic [DATA_W-1:0]     pwdata,
    input  logic [DATA_W-1:0]     prdata,
    input  logic                  pready,
    input  logic                  pslverr,
    output logic [1:0]            dbg_state
);

    localparam logic [1:0] IDLE   = ST_IDLE;
    localparam logic [1:0] SETUP  = ST_SETUP;
    localparam logic [1:0] ACCESS = ST_ACCESS;
    localparam logic [1:0] RESP   = ST_RESP;

    logic [1:0] state;
    logic       expired;
    req_t       req_in;

    assign req_in    = '{write: req_write, addr: req_addr, wdata: DEF_DATA_W'(req_wdata)};
    assign dbg_state = state;

    apb_timeout_ctr #(.LIMIT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (state == RESP && rsp_ready),
        .en      (state == ACCESS && !pready),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        psel      <= 1'b1;
                        penable   <= 1'b0;
                        pwrite    <= req_in.write;
                        paddr     <= ADDR_W'(req_in.addr);
                        pwdata    <= DATA_W'(req_in.wdata);
                        req_ready <= 1'b0;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    // pready wins over a timeout landing in the same cycle.
                    if (pready) begin
                        rsp_rdata <= (!pwrite && !pslverr) ? prdata : '0;
                        rsp_err   <= pslverr;
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if (expired) begin
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_apb_master.sv
// Randomized bench for i2c_apb_master against a transaction-timing model.
module tb_i2c_apb_master;
    import i2c_apb_pkg::*;

    localparam int T       = 4;
    localparam int MAX_CYC = 5000;
    localparam int N_RAND  = 30;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid, req_ready, req_write;
    logic [6:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid, rsp_ready, rsp_err;
    logic [7:0] rsp_rdata;
    logic       psel, penable, pwrite;
    logic [7:0] paddr, pwdata, prdata;
    logic       pready, pslverr;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    i2c_apb_master #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(T)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr), .dbg_state(dbg_state)
    );

    typedef struct {
        bit       write;
        bit [6:0] addr;
        bit [7:0] wdata;
        bit [7:0] prdata;
        bit       slverr;
        int       w;
        int       bp;
        int       rst_at;
        bit       early;
        int       gap;
    } txn_t;

    txn_t       tq[$];
    logic [8:0] exp_q[$];
    int         n_pass = 0;
    int         n_total = 0;

    // Model state: a transfer is described by its handshake edge (r=0)
    // and the edge e_done at which the response becomes visible.
    txn_t cur, pend;
    bit   busy = 0, after_reset = 0, chk_on = 0, has_pend = 0, presented = 0;
    int   r = 0, e_done = 0, tidx = 0, pidx = 0, next_idx = 0, gap_left = 0, cyc = 0;

    int         resp_r[64], psel_n[64], pen_n[64], rv_n[64], psel_first[64];
    logic [7:0] resp_d[64];
    logic       resp_e[64];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        else n_pass++;
    endtask

    function automatic txn_t mk(bit wr, bit [6:0] a, bit [7:0] wd, bit [7:0] pd, bit se,
                                int w, int bp, int ra, bit early, int gap);
        txn_t t;
        t.write = wr; t.addr = a; t.wdata = wd; t.prdata = pd; t.slverr = se;
        t.w = w; t.bp = bp; t.rst_at = ra; t.early = early; t.gap = gap;
        return t;
    endfunction

    function automatic int done_edge(txn_t t);
        return (t.w < T) ? t.w + 2 : T + 1;
    endfunction

    function automatic logic [8:0] exp_rsp(txn_t t);
        if (t.w >= T) return {1'b1, 8'h00};
        if (t.slverr) return {1'b1, 8'h00};
        return {1'b0, t.write ? 8'h00 : t.prdata};
    endfunction

    // Per-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            if (after_reset) begin
                chk("rst_req_ready", req_ready, 1);
                chk("rst_rsp_valid", rsp_valid, 0);
                chk("rst_psel", psel, 0);
                chk("rst_penable", penable, 0);
                chk("rst_regs", {pwrite, paddr, pwdata, rsp_rdata, rsp_err}, 0);
                chk("rst_state", dbg_state, ST_IDLE);
            end else begin
                chk("req_ready", req_ready, !busy);
                chk("psel", psel, busy && r < e_done);
                chk("penable", penable, busy && r >= 1 && r < e_done);
                chk("rsp_valid", rsp_valid, busy && r >= e_done);
                chk("state", dbg_state, !busy ? ST_IDLE : (r == 0) ? ST_SETUP :
                                        (r < e_done) ? ST_ACCESS : ST_RESP);
                if (busy && r < e_done)
                    chk("apb_req", {pwrite, paddr, pwdata}, {cur.write, 1'b0, cur.addr, cur.wdata});
                if (busy && r >= e_done)
                    chk("rsp_hold", {rsp_err, rsp_rdata}, exp_rsp(cur));
            end
            if (rsp_valid === 1'b1 && rsp_ready) begin
                if (exp_q.size() == 0) chk("rsp_unexpected", 1, 0);
                else chk("rsp_scoreboard", {rsp_err, rsp_rdata}, exp_q.pop_front());
            end
            if (busy) begin
                if (psel === 1'b1) begin
                    psel_n[tidx]++;
                    if (psel_first[tidx] < 0) psel_first[tidx] = cyc;
                end
                if (penable === 1'b1) pen_n[tidx]++;
                if (rsp_valid === 1'b1) begin
                    rv_n[tidx]++;
                    if (resp_r[tidx] < 0) begin
                        resp_r[tidx] = r;
                        resp_d[tidx] = rsp_rdata;
                        resp_e[tidx] = rsp_err;
                    end
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 64; i++) begin
            resp_r[i] = -1; psel_first[i] = -1; psel_n[i] = 0; pen_n[i] = 0; rv_n[i] = 0;
            resp_d[i] = '0; resp_e[i] = 1'b0;
        end
        tq.push_back(mk(1, 7'h50, 8'hA5, 8'h11, 0, 0, 0, -1, 0, 0));
        tq.push_back(mk(0, 7'h50, 8'h00, 8'hA5, 0, 2, 0, -1, 0, 0));
        tq.push_back(mk(0, 7'h51, 8'h00, 8'h5A, 1, 0, 0, -1, 0, 0));
        tq.push_back(mk(0, 7'h12, 8'h00, 8'h77, 0, T, 2, -1, 0, 1));
        tq.push_back(mk(0, 7'h13, 8'h00, 8'hA6, 0, 0, 5, -1, 0, 0));
        tq.push_back(mk(1, 7'h20, 8'h3C, 8'h00, 0, 3, 0, 1, 1, 0));
        for (int i = 0; i < N_RAND; i++)
            tq.push_back(mk(1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom), 8'($urandom),
                            ($urandom_range(0, 3) == 0), $urandom_range(0, 6), $urandom_range(0, 3),
                            -1, 1'($urandom_range(0, 1)), $urandom_range(0, 2)));

        rst = 1; req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0;
        rsp_ready = 0; prdata = '0; pready = 0; pslverr = 0;

        while (cyc < MAX_CYC) begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                busy = 0;
                after_reset = 1;
                exp_q.delete();
            end else begin
                after_reset = 0;
                if (!busy) begin
                    if (req_valid) begin
                        busy = 1; r = 0; cur = pend; tidx = pidx;
                        has_pend = 0; presented = 0;
                        e_done = done_edge(cur);
                        exp_q.push_back(exp_rsp(cur));
                    end
                end else begin
                    r++;
                    if (r == e_done + cur.bp + 1) busy = 0;
                end
            end
            chk_on = 1;
            if (next_idx == tq.size() && !has_pend && !busy && !rst && cyc > 3) break;
            #1;
            rst = (cyc < 3) || (busy && r == cur.rst_at);
            if (!has_pend && next_idx < tq.size()) begin
                pend = tq[next_idx]; pidx = next_idx; next_idx++;
                has_pend = 1; gap_left = pend.gap;
            end
            if (has_pend && !presented) begin
                if (busy ? pend.early : (gap_left == 0)) presented = 1;
                else if (!busy) gap_left--;
            end
            req_valid = presented;
            req_write = presented ? pend.write : 1'($urandom);
            req_addr  = presented ? pend.addr  : 7'($urandom);
            req_wdata = presented ? pend.wdata : 8'($urandom);
            if (busy && r == 1 + cur.w) begin
                pready = 1; pslverr = cur.slverr; prdata = cur.prdata;
            end else begin
                pready  = (!busy || r == 0 || r >= e_done) ? 1'($urandom_range(0, 1)) : 1'b0;
                pslverr = 1'($urandom_range(0, 1));
                prdata  = 8'($urandom);
            end
            rsp_ready = (busy && r >= e_done) ? (r == e_done + cur.bp) : 1'($urandom_range(0, 1));
        end
        if (cyc >= MAX_CYC) begin
            n_total++;
            $display("FAIL cycle_budget: got %0d cycles, required fewer than %0d", cyc, MAX_CYC);
        end
        @(negedge clk);
        chk_on = 0;

        // Hand-computed expectations for the directed transfers.
        chk("t0_rsp_edge", resp_r[0], 2);
        chk("t0_psel_cycles", psel_n[0], 2);
        chk("t0_penable_cycles", pen_n[0], 1);
        chk("t0_rsp", {resp_e[0], resp_d[0]}, 9'h000);
        chk("t1_rsp_edge", resp_r[1], 4);
        chk("t1_rsp", {resp_e[1], resp_d[1]}, 9'h0A5);
        chk("t2_rsp", {resp_e[2], resp_d[2]}, 9'h100);
        chk("t3_rsp_edge", resp_r[3], T + 1);
        chk("t3_access_cycles", pen_n[3], T);
        chk("t3_rsp", {resp_e[3], resp_d[3]}, 9'h100);
        chk("t4_rsp", {resp_e[4], resp_d[4]}, 9'h0A6);
        chk("t4_rsp_valid_cycles", rv_n[4], 6);
        chk("t5_accept_gap", psel_first[5] - psel_first[4], 9);
        chk("t5_no_rsp", resp_r[5], -1);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
